// File: rtl/pc_stack_unit.sv
// Parametrised program counter with a hardware return-address stack.
// Updates on the falling clock edge; strobe priority call > ret > load > rel > inc.
module pc_stack_unit #(
  parameter int PC_WIDTH     = 6,
  parameter int BUS_WIDTH    = 16,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pcload,
  input  logic                 pcinc,
  input  logic                 pcrel,
  input  logic                 pccall,
  input  logic                 pcret,
  input  logic                 err_clr,
  input  logic [BUS_WIDTH-1:0] bus,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic                 stack_full,
  output logic                 stack_empty,
  output logic                 stack_ovf,
  output logic                 stack_unf
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                ovf_reg, ovf_next;
  logic                unf_reg, unf_next;
  logic                push;
  logic [PC_WIDTH-1:0] stack_reg [STACK_DEPTH];

  logic [PC_WIDTH-1:0] bus_pc;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       rd_idx;
  logic                bus_unused;

  assign bus_pc     = bus[PC_WIDTH-1:0];
  assign bus_unused = ^bus;
  assign pc_plus1   = pc_reg + PC_WIDTH'(1);
  // count is below STACK_DEPTH whenever a push happens and nonzero on a pop
  assign wr_idx     = AW'(count_reg);
  assign rd_idx     = AW'(count_reg - CW'(1));

  assign stack_full  = (count_reg == CW'(STACK_DEPTH));
  assign stack_empty = (count_reg == CW'(0));
  assign pc_out      = pc_reg;
  assign stack_ovf   = ovf_reg;
  assign stack_unf   = unf_reg;

  always_comb begin
    pc_next    = pc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg & ~err_clr;
    unf_next   = unf_reg & ~err_clr;
    push       = 1'b0;
    if (pccall) begin
      if (stack_full) begin
        ovf_next = 1'b1;
      end else begin
        push       = 1'b1;
        count_next = count_reg + CW'(1);
        pc_next    = bus_pc;
      end
    end else if (pcret) begin
      if (stack_empty) begin
        unf_next = 1'b1;
      end else begin
        pc_next    = stack_reg[rd_idx];
        count_next = count_reg - CW'(1);
      end
    end else if (pcload) begin
      pc_next = bus_pc;
    end else if (pcrel) begin
      // two's complement offset: modular add of the raw field is the signed add
      pc_next = pc_reg + bus_pc;
    end else if (pcinc) begin
      pc_next = pc_plus1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= PC_WIDTH'(RESET_VECTOR);
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Entry storage carries no reset; count alone defines which entries are live.
  always_ff @(negedge clk) begin
    if (push && rst_n) begin
      stack_reg[wr_idx] <= pc_plus1;
    end
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter, successor to the fixed 6-bit PC.
- Adds the following features:
  - configurable PC width
  - reset vector
  - PC-relative branch
  - call/return with an internal hardware return-address stack
  - full/empty flags and sticky overflow/underflow error flags
- Sits between the control unit (which drives the one-hot-ish control strobes) and the 16-bit internal bus.
- pc_out feeds memory address logic.

Parameters:
- PC_WIDTH, 6: width of PC and of each stack entry; 1 <= PC_WIDTH <= BUS_WIDTH.
- BUS_WIDTH, 16: internal bus width; only bus[PC_WIDTH-1:0] is used.
- STACK_DEPTH, 4: number of return-address entries; must be >= 2.
- RESET_VECTOR, 0: value loaded into PC on reset.

Ports:
- clk  input  1  system clock; all state updates on falling edge.
- rst_n  input  1  asynchronous active-low reset.
- pcload  input  1  absolute jump: PC <= bus[PC_WIDTH-1:0].
- pcinc  input  1  PC <= PC + 1.
- pcrel  input  1  relative branch: PC <= PC + signed(bus[PC_WIDTH-1:0]).
- pccall  input  1  push PC+1, then PC <= bus[PC_WIDTH-1:0].
- pcret  input  1  pop top of stack into PC.
- err_clr  input  1  clears sticky error flags.
- bus  input  BUS_WIDTH  internal bus.
- pc_out  output  PC_WIDTH  current PC, combinationally equal to the PC register.
- stack_full  output  1  entry count == STACK_DEPTH.
- stack_empty  output  1  entry count == 0.
- stack_ovf  output  1  sticky: a call was attempted while full.
- stack_unf  output  1  sticky: a return was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - PC = RESET_VECTOR; stack count = 0.
  - stack_empty = 1, stack_full = 0, stack_ovf = 0, stack_unf = 0.
  - Stack entry contents need not be cleared.
- Reset asserted mid-operation overrides any strobe in the same cycle. After rst_n deasserts, the first falling edge acts normally.
- Updates occur on the falling edge of clk. Latency is one edge: pc_out shows the new value immediately after the edge.
- Strobe priority, highest first: pccall > pcret > pcload > pcrel > pcinc. Exactly one action is taken per edge; lower strobes are ignored. No strobe: PC holds.
- Arithmetic is modulo 2^PC_WIDTH:
  - Increment: all-ones -> 0.
  - Relative offset is two's complement of width PC_WIDTH, relative to the current PC (not PC+1). Wrap is silent.
- Call:
  - Not full: stack[count] <= PC + 1 (wrapped); count += 1; PC <= bus[PC_WIDTH-1:0].
  - Full: no push, PC unchanged, stack_ovf <= 1.
- Return:
  - Not empty: PC <= stack[count-1]; count -= 1.
  - Empty: PC unchanged, stack_unf <= 1.
- Flags:
  - stack_full and stack_empty are combinational from count.
  - count ranges 0..STACK_DEPTH; its width is wide enough to hold STACK_DEPTH.
- err_clr:
  - Clears both sticky flags on the edge.
  - If the same edge also sets a flag (call-on-full or ret-on-empty), the set wins and the flag stays 1.
  - err_clr does not affect PC or the stack.
- LIFO ordering is strict. Nested calls up to STACK_DEPTH return in reverse order.
- Bus bits above PC_WIDTH are ignored in all modes.

Test Plan:
1. Reset/increment:
   - Stimulus: RESET_VECTOR=0, PC_WIDTH=6; rst_n low, release; pulse pcinc for 65 edges.
   - Required: pc_out reads 0 during reset, then 1..63, then 0 at the 64th increment, then 1; stack_empty=1 throughout.
2. Load and relative:
   - Stimulus: pcload with bus=16'hFFE5.
   - Required: pc_out=6'h25.
   - Stimulus: pcrel with bus=6'h3E (-2).
   - Required: pc_out=6'h23.
   - Stimulus: pcrel with bus=6'h1F from PC=6'h23.
   - Required: pc_out=6'h02 (wrap).
3. Nested call/return:
   - Stimulus: from PC=5, pccall bus=20; at PC=20, pccall bus=40; then pcret twice.
   - Required: pc_out 20, 40, 21, 6; stack_empty returns to 1.
4. Overflow/underflow:
   - Stimulus: STACK_DEPTH=4; 4 calls, then a 5th call with bus=9.
   - Required: PC unchanged, stack_full=1, stack_ovf=1.
   - Stimulus: 4 returns, then a 5th return.
   - Required: PC unchanged, stack_unf=1.
   - Stimulus: err_clr.
   - Required: both flags 0.
5. Priority:
   - Stimulus: pccall+pcload+pcinc together with bus=12 from PC=3.
   - Required: pc_out=12, count=1, top entry=4.
   - Stimulus: pcret+pcinc together.
   - Required: pc_out=4.
6. Async reset mid-sequence:
   - Stimulus: after 2 calls, drop rst_n between clock edges.
   - Required: pc_out=RESET_VECTOR immediately, stack_empty=1, flags 0; then pcret sets stack_unf.
